control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  3  instruction opcode from datapath DI register; sampled only in state D2.
REQ-004 SHALL have port: toCU  input  1  datapath zero flag; sampled only in D2 for JZ.
REQ-005 SHALL have port: memReady  input  1  memory completion strobe; high = current mr/mw access completes this cycle.
REQ-006 SHALL have ports (all output, 1 bit): pcEn, selAddress (0=PC, 1=instruction address), mr, mw, wordRegEn, LSEn, DIEn, selData (1=accumulator drives memory data), selALUsrc, enb (accumulator write), dataRegEn, resultRegEn, CEn, ZEn, NEn, selPC (1=PC loads jump target).
REQ-007 SHALL have port: aluOp  output  2  00 pass, 01 add, 10 and, 11 unused.

Function
REQ-008 SHALL implement states F1, D1, F2, D2, MRD, EX, WB, MWR, JMP, HALT; one-hot or binary encoding free.
REQ-009 SHALL decode outputs from state; any output not listed for a state is 0; aluOp 00 unless listed.
REQ-010 F1: mr=1, selAddress=0, wordRegEn=1; pcEn=memReady; stay while memReady=0; go to D1 on memReady=1.
REQ-011 D1: DIEn=1; go to F2 unconditionally.
REQ-012 F2: mr=1, selAddress=0, LSEn=1; pcEn=memReady; stay while memReady=0; go to D2 on memReady=1.
REQ-013 D2: no outputs; next state by opcode: 000 ADD, 001 AND, 010 LDA -> MRD; 011 STA -> MWR; 100 JMP -> JMP; 101 JZ -> JMP if toCU=1, else F1; 110 NOP -> F1; 111 HLT -> HALT.
REQ-014 Opcode SHALL be captured into an internal register at the D2 edge; later opcode input changes SHALL NOT affect MRD/EX/WB.
REQ-015 MRD: selAddress=1, mr=1, dataRegEn=memReady; stay while memReady=0; go to EX on memReady=1.
REQ-016 EX: selALUsrc=1, resultRegEn=1, ZEn=1, NEn=1; aluOp 01 for ADD, 10 for AND, 00 for LDA; CEn=1 only for ADD; go to WB.
REQ-017 WB: enb=1; go to F1.
REQ-018 MWR: selAddress=1, mw=1, selData=1; stay while memReady=0; go to F1 on memReady=1.
REQ-019 JMP: selPC=1, pcEn=1; go to F1.
REQ-020 HALT: all outputs 0; remain until rst.
REQ-021 mr and mw SHALL never be high in the same cycle; pcEn SHALL never be high with memReady=0 in F1/F2.
REQ-022 With memReady tied 1, latencies (cycles F1 entry to next F1 entry): ADD/AND/LDA 7, STA 5, JMP/taken JZ 5, untaken JZ/NOP 4.
REQ-023 memReady outside F1, F2, MRD, MWR SHALL be ignored.

Reset
REQ-024 rst=1 SHALL force state F1 and all outputs 0 immediately, independent of clk, including mid-access (pending mw dropped same cycle).
REQ-025 First rising clk edge after rst deasserts SHALL leave state F1 with F1 outputs active in the cycle after deassertion.
REQ-026 Captured opcode register SHALL reset to 110 (NOP).

Verification
REQ-027 Reset, memReady=1, opcode=010 -> F1,D1,F2,D2,MRD,EX,WB,F1; EX shows aluOp=00, CEn=0, ZEn=NEn=1; enb=1 only in WB.
REQ-028 opcode=000, memReady=0 for 3 cycles in MRD -> MRD held 4 cycles, dataRegEn=1 only in 4th; EX aluOp=01, CEn=1.
REQ-029 opcode=101 with toCU=0 -> D2 to F1, selPC never 1; repeat with toCU=1 -> JMP cycle with selPC=pcEn=1.
REQ-030 opcode=011, memReady=0 two cycles, rst pulsed 1 in second MWR cycle -> mw falls to 0 asynchronously, next active state F1.
REQ-031 opcode=111 -> HALT; 20 cycles with memReady toggling -> all outputs 0; rst then clears to F1.
REQ-032 Every test: assert mr&mw never both 1, and pcEn never 1 in F1/F2 while memReady=0.

Source files
------------

// File: rtl/control_unit_if.sv
// Control bus between the instruction-sequencing control unit and its datapath.
// The master side is the control unit; the slave side is the datapath or a bench.
interface control_unit_if;
    logic [2:0] opcode;
    logic       toCU;
    logic       memReady;
    logic       pcEn;
    logic       selAddress;
    logic       mr;
    logic       mw;
    logic       wordRegEn;
    logic       LSEn;
    logic       DIEn;
    logic       selData;
    logic       selALUsrc;
    logic       enb;
    logic       dataRegEn;
    logic       resultRegEn;
    logic       CEn;
    logic       ZEn;
    logic       NEn;
    logic       selPC;
    logic [1:0] aluOp;

    modport master (
        input  opcode, toCU, memReady,
        output pcEn, selAddress, mr, mw, wordRegEn, LSEn, DIEn, selData,
               selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn, selPC, aluOp
    );

    modport slave (
        output opcode, toCU, memReady,
        input  pcEn, selAddress, mr, mw, wordRegEn, LSEn, DIEn, selData,
               selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn, selPC, aluOp
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit: two-word fetch, decode, optional memory read/write,
// execute/writeback and jumps. Control outputs are registered from the next state.
module control_unit (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        F1, D1, F2, D2, MRD, EX, WB, MWR, JMP, HALT
    } state_t;

    typedef struct packed {
        logic       fetch;
        logic       mrdWait;
        logic       pcEn;
        logic       selAddress;
        logic       mr;
        logic       mw;
        logic       wordRegEn;
        logic       LSEn;
        logic       DIEn;
        logic       selData;
        logic       selALUsrc;
        logic       enb;
        logic       resultRegEn;
        logic       CEn;
        logic       ZEn;
        logic       NEn;
        logic       selPC;
        logic [1:0] aluOp;
    } ctrl_t;

    state_t     state;
    state_t     nextState;
    ctrl_t      ctrl;
    logic [2:0] opReg;
    logic       armed;

    // fetch/mrdWait mark states whose enables follow memReady combinationally
    function automatic ctrl_t decode(input state_t s, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            F1: begin
                c.fetch     = 1'b1;
                c.mr        = 1'b1;
                c.wordRegEn = 1'b1;
            end
            D1: c.DIEn = 1'b1;
            F2: begin
                c.fetch = 1'b1;
                c.mr    = 1'b1;
                c.LSEn  = 1'b1;
            end
            MRD: begin
                c.mrdWait    = 1'b1;
                c.selAddress = 1'b1;
                c.mr         = 1'b1;
            end
            EX: begin
                c.selALUsrc   = 1'b1;
                c.resultRegEn = 1'b1;
                c.ZEn         = 1'b1;
                c.NEn         = 1'b1;
                case (op)
                    3'b000: begin
                        c.aluOp = 2'b01;
                        c.CEn   = 1'b1;
                    end
                    3'b001: c.aluOp = 2'b10;
                    default: c.aluOp = 2'b00;
                endcase
            end
            WB: c.enb = 1'b1;
            MWR: begin
                c.selAddress = 1'b1;
                c.mw         = 1'b1;
                c.selData    = 1'b1;
            end
            JMP: begin
                c.selPC = 1'b1;
                c.pcEn  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nextState = state;
        case (state)
            F1:  if (bus.memReady) nextState = D1;
            D1:  nextState = F2;
            F2:  if (bus.memReady) nextState = D2;
            D2: begin
                case (bus.opcode)
                    3'b000, 3'b001, 3'b010: nextState = MRD;
                    3'b011:  nextState = MWR;
                    3'b100:  nextState = JMP;
                    3'b101:  nextState = bus.toCU ? JMP : F1;
                    3'b110:  nextState = F1;
                    default: nextState = HALT;
                endcase
            end
            MRD: if (bus.memReady) nextState = EX;
            EX:  nextState = WB;
            WB:  nextState = F1;
            MWR: if (bus.memReady) nextState = F1;
            JMP: nextState = F1;
            default: nextState = HALT;
        endcase
    end

    // After reset the first edge only arms the outputs for F1 without advancing,
    // so F1 is visible for a full cycle before any memory handshake is honoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= F1;
            armed <= 1'b0;
            ctrl  <= '0;
            opReg <= 3'b110;
        end else if (!armed) begin
            armed <= 1'b1;
            ctrl  <= decode(F1, opReg);
        end else begin
            state <= nextState;
            ctrl  <= decode(nextState, opReg);
            if (state == D2) opReg <= bus.opcode;
        end
    end

    assign bus.pcEn        = ctrl.pcEn | (ctrl.fetch & bus.memReady);
    assign bus.dataRegEn   = ctrl.mrdWait & bus.memReady;
    assign bus.selAddress  = ctrl.selAddress;
    assign bus.mr          = ctrl.mr;
    assign bus.mw          = ctrl.mw;
    assign bus.wordRegEn   = ctrl.wordRegEn;
    assign bus.LSEn        = ctrl.LSEn;
    assign bus.DIEn        = ctrl.DIEn;
    assign bus.selData     = ctrl.selData;
    assign bus.selALUsrc   = ctrl.selALUsrc;
    assign bus.enb         = ctrl.enb;
    assign bus.resultRegEn = ctrl.resultRegEn;
    assign bus.CEn         = ctrl.CEn;
    assign bus.ZEn         = ctrl.ZEn;
    assign bus.NEn         = ctrl.NEn;
    assign bus.selPC       = ctrl.selPC;
    assign bus.aluOp       = ctrl.aluOp;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: each step pushes the expected
// output word for the cycle and the DUT outputs are popped and compared.
module tb_control_unit;

    typedef enum {T_ZERO, T_F1, T_D1, T_F2, T_D2, T_MRD, T_EX, T_WB, T_MWR, T_JMP} tst_t;

    typedef struct packed {
        logic       pcEn;
        logic       selAddress;
        logic       mr;
        logic       mw;
        logic       wordRegEn;
        logic       LSEn;
        logic       DIEn;
        logic       selData;
        logic       selALUsrc;
        logic       enb;
        logic       dataRegEn;
        logic       resultRegEn;
        logic       CEn;
        logic       ZEn;
        logic       NEn;
        logic       selPC;
        logic [1:0] aluOp;
    } out_t;

    typedef struct {
        out_t  exp;
        string tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [2:0] modelOp = 3'b110;
    sb_t  scoreboard[$];

    control_unit_if bus();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic out_t expectFor(input tst_t st, input logic mrdy, input logic [2:0] op);
        out_t e;
        e = '0;
        case (st)
            T_F1:  begin e.mr = 1; e.wordRegEn = 1; e.pcEn = mrdy; end
            T_D1:  e.DIEn = 1;
            T_F2:  begin e.mr = 1; e.LSEn = 1; e.pcEn = mrdy; end
            T_MRD: begin e.selAddress = 1; e.mr = 1; e.dataRegEn = mrdy; end
            T_EX: begin
                e.selALUsrc = 1; e.resultRegEn = 1; e.ZEn = 1; e.NEn = 1;
                if (op == 3'b000) begin e.aluOp = 2'b01; e.CEn = 1; end
                else if (op == 3'b001) e.aluOp = 2'b10;
            end
            T_WB:  e.enb = 1;
            T_MWR: begin e.selAddress = 1; e.mw = 1; e.selData = 1; end
            T_JMP: begin e.selPC = 1; e.pcEn = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic out_t sampleOutputs();
        out_t o;
        o = {bus.pcEn, bus.selAddress, bus.mr, bus.mw, bus.wordRegEn, bus.LSEn,
             bus.DIEn, bus.selData, bus.selALUsrc, bus.enb, bus.dataRegEn,
             bus.resultRegEn, bus.CEn, bus.ZEn, bus.NEn, bus.selPC, bus.aluOp};
        return o;
    endfunction

    task automatic checkOutput();
        sb_t  item;
        out_t obs;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
            return;
        end
        item = scoreboard.pop_front();
        obs  = sampleOutputs();
        checks++;
        assert (obs === item.exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %05h expected %05h", item.tag, obs, item.exp);
        end
    endtask

    task automatic pushExpected(input tst_t st, input logic mrdy, input string tag);
        sb_t item;
        item.exp = expectFor(st, mrdy, modelOp);
        item.tag = tag;
        scoreboard.push_back(item);
    endtask

    task automatic applyStimulus(input logic mrdy, input logic [2:0] op, input logic tz,
                                 input tst_t st, input string tag);
        @(negedge clk);
        bus.memReady = mrdy;
        bus.opcode   = op;
        bus.toCU     = tz;
        pushExpected(st, mrdy, tag);
        #1 checkOutput();
    endtask

    task automatic releaseReset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        pushExpected(T_ZERO, bus.memReady, tag);
        #1 checkOutput();
    endtask

    task automatic fetchBoth(input logic [2:0] op, input string tag);
        applyStimulus(1, op, 0, T_F1, {tag, "_f1"});
        applyStimulus(1, op, 0, T_D1, {tag, "_d1"});
        applyStimulus(1, op, 0, T_F2, {tag, "_f2"});
    endtask

    // Bus protocol invariants, sampled mid-cycle on every cycle
    always @(negedge clk) begin
        #2;
        checks++;
        assert (!(bus.mr === 1'b1 && bus.mw === 1'b1)) else begin
            errors++;
            $error("[TB] FAIL mr_mw_overlap: observed mr=%b mw=%b expected not both 1", bus.mr, bus.mw);
        end
        if ((bus.wordRegEn === 1'b1 || bus.LSEn === 1'b1) && bus.memReady === 1'b0) begin
            checks++;
            assert (bus.pcEn === 1'b0) else begin
                errors++;
                $error("[TB] FAIL pcen_no_ready: observed pcEn=%b expected 0", bus.pcEn);
            end
        end
    end

    initial begin
        bus.memReady = 1'b1;
        bus.opcode   = 3'b010;
        bus.toCU     = 1'b0;

        @(negedge clk);
        pushExpected(T_ZERO, 1, "reset_hold");
        #1 checkOutput();
        releaseReset("reset_release");

        // LDA with memory always ready
        modelOp = 3'b010;
        fetchBoth(3'b010, "lda");
        applyStimulus(1, 3'b010, 0, T_D2,  "lda_d2");
        applyStimulus(1, 3'b010, 0, T_MRD, "lda_mrd");
        applyStimulus(1, 3'b010, 0, T_EX,  "lda_ex");
        applyStimulus(1, 3'b010, 0, T_WB,  "lda_wb");

        // ADD with stalled fetch and operand read; opcode input changes after decode
        modelOp = 3'b000;
        applyStimulus(0, 3'b000, 0, T_F1, "add_f1_wait");
        applyStimulus(0, 3'b000, 0, T_F1, "add_f1_wait2");
        fetchBoth(3'b000, "add");
        applyStimulus(1, 3'b000, 0, T_D2,  "add_d2");
        applyStimulus(0, 3'b111, 0, T_MRD, "add_mrd_w1");
        applyStimulus(0, 3'b111, 0, T_MRD, "add_mrd_w2");
        applyStimulus(0, 3'b111, 0, T_MRD, "add_mrd_w3");
        applyStimulus(1, 3'b111, 0, T_MRD, "add_mrd_done");
        applyStimulus(1, 3'b111, 0, T_EX,  "add_ex");
        applyStimulus(1, 3'b111, 0, T_WB,  "add_wb");

        // AND
        modelOp = 3'b001;
        fetchBoth(3'b001, "and");
        applyStimulus(1, 3'b001, 0, T_D2,  "and_d2");
        applyStimulus(1, 3'b001, 0, T_MRD, "and_mrd");
        applyStimulus(1, 3'b001, 0, T_EX,  "and_ex");
        applyStimulus(1, 3'b001, 0, T_WB,  "and_wb");

        // JZ untaken, JZ taken, JMP, NOP
        fetchBoth(3'b101, "jzn");
        applyStimulus(1, 3'b101, 0, T_D2,  "jzn_d2");
        fetchBoth(3'b101, "jzt");
        applyStimulus(1, 3'b101, 1, T_D2,  "jzt_d2");
        applyStimulus(1, 3'b101, 1, T_JMP, "jzt_jmp");
        fetchBoth(3'b100, "jmp");
        applyStimulus(1, 3'b100, 0, T_D2,  "jmp_d2");
        applyStimulus(0, 3'b100, 0, T_JMP, "jmp_jmp");
        fetchBoth(3'b110, "nop");
        applyStimulus(1, 3'b110, 0, T_D2,  "nop_d2");

        // STA aborted by reset during the pending write
        fetchBoth(3'b011, "sta");
        applyStimulus(1, 3'b011, 0, T_D2,  "sta_d2");
        applyStimulus(0, 3'b011, 0, T_MWR, "sta_mwr1");
        applyStimulus(0, 3'b011, 0, T_MWR, "sta_mwr2");
        #2 rst = 1'b1;
        pushExpected(T_ZERO, 0, "sta_async_reset");
        #1 checkOutput();
        releaseReset("sta_reset_release");
        bus.memReady = 1'b1;

        // STA completing normally
        fetchBoth(3'b011, "sta2");
        applyStimulus(1, 3'b011, 0, T_D2,  "sta2_d2");
        applyStimulus(1, 3'b011, 0, T_MWR, "sta2_mwr");
        applyStimulus(1, 3'b011, 0, T_F1,  "sta2_next_f1");
        applyStimulus(1, 3'b011, 0, T_D1,  "sta2_next_d1");
        applyStimulus(1, 3'b111, 0, T_F2,  "hlt_f2");

        // HLT ignores memReady until reset
        applyStimulus(1, 3'b111, 0, T_D2,  "hlt_d2");
        for (int i = 0; i < 20; i++)
            applyStimulus(logic'(i % 2), 3'b111, 0, T_ZERO, $sformatf("halt_%0d", i));
        @(negedge clk);
        rst = 1'b1;
        pushExpected(T_ZERO, bus.memReady, "halt_reset");
        #1 checkOutput();
        releaseReset("halt_release");
        applyStimulus(1, 3'b111, 0, T_F1, "halt_after_f1");
        applyStimulus(1, 3'b111, 0, T_D1, "halt_after_d1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
